// File: rtl/axis_cmd_arbiter_pkg.sv
// Shared types and defaults for the round-robin command arbiter.
// The arbiter shares one serial command sink between several AXI-Stream sources.
package axis_cmd_arbiter_pkg;

  localparam int DEFAULT_NUM_PORTS  = 4;
  localparam int DEFAULT_DATA_WIDTH = 72;
  localparam int DEFAULT_CNTR_WIDTH = 32;
  localparam int DEFAULT_ID_WIDTH   = 2;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } arb_state_t;

  // Index width for a port count. A lone port still needs one bit.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_cmd_arbiter_if.sv
// Stream bundle between the command sources, the arbiter and the serializer sink.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment that drives the sources and acts as the sink.
interface axis_cmd_arbiter_if
  import axis_cmd_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = DEFAULT_ID_WIDTH
) ();

  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [ID_WIDTH-1:0]             m_axis_tid;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );

endinterface

// File: rtl/axis_cmd_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// It returns the first requester at or after ptr, wrapping modulo NUM_PORTS.
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_PORTS);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/axis_cmd_arbiter.sv
// Round-robin arbiter that forwards one command word per grant through a registered output.
// After each output handshake it holds off new grants for a programmable idle gap.
module axis_cmd_arbiter
  import axis_cmd_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNTR_WIDTH = DEFAULT_CNTR_WIDTH,
  parameter int ID_WIDTH   = DEFAULT_ID_WIDTH
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
  axis_cmd_arbiter_if.slave     bus,
  output logic                  busy
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  arb_state_t            state, state_next;
  logic [IDX_W-1:0]      ptr, ptr_next, gnt_idx;
  logic [NUM_PORTS-1:0]  gnt;
  logic                  any, accept, handshake;
  logic [CNTR_WIDTH-1:0] gap_cnt;
  logic [DATA_WIDTH-1:0] words [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_words
    assign words[g] = bus.s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req     (bus.s_axis_tvalid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign ptr_next = (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // Ready is offered only in IDLE and is masked during reset.
  // This keeps sources from handshaking while the arbiter is held.
  always_comb begin
    state_next        = state;
    accept            = 1'b0;
    handshake         = 1'b0;
    bus.s_axis_tready = '0;
    busy              = (state != IDLE);
    case (state)
      IDLE: begin
        if (!areset) bus.s_axis_tready = gnt;
        if (any) begin
          accept     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (bus.m_axis_tready) begin
          handshake  = 1'b1;
          state_next = (cfg_data == '0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == CNTR_WIDTH'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr               <= '0;
      gap_cnt           <= '0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tid    <= '0;
      bus.m_axis_tvalid <= 1'b0;
    end else begin
      if (accept) begin
        bus.m_axis_tdata  <= words[gnt_idx];
        bus.m_axis_tid    <= ID_WIDTH'(gnt_idx);
        bus.m_axis_tvalid <= 1'b1;
        ptr               <= ptr_next;
      end
      // The gap length is captured at the handshake, so cfg_data may change freely afterwards.
      if (handshake) begin
        bus.m_axis_tvalid <= 1'b0;
        gap_cnt           <= cfg_data;
      end
      if (state == GAP) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_cmd_arbiter.sv
// Scoreboard bench for axis_cmd_arbiter. A behavioural model predicts grants and timing.
// A negedge monitor compares every DUT output against that prediction.
module tb_axis_cmd_arbiter;

  localparam int NP = 4;
  localparam int DW = 72;
  localparam int CW = 32;
  localparam int IW = 2;
  localparam logic [DW-1:0] RR_BASE = 72'h250000_14_AAAA_11_0000;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic          busy;

  axis_cmd_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axis_cmd_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .CNTR_WIDTH (CW),
    .ID_WIDTH   (IW)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .cfg_data (cfg_data),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 aclk = ~aclk;

  int    compared = 0;
  int    mismatched = 0;
  int    cyc = 0;
  exp_t  exp_q[$];
  int    tid_log[$];
  int    hs_cyc[$];

  // Model state: a word the sink still owes us, plus the remaining idle-gap cycles.
  int     m_ptr = 0;
  bit     m_holding = 1'b0;
  longint m_gap = 0;

  function automatic int pick(logic [NP-1:0] v, int p);
    for (int k = 0; k < NP; k++) begin
      if (v[(p + k) % NP]) return (p + k) % NP;
    end
    return -1;
  endfunction

  task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(logic [NP-1:0] valid, logic ready, int cycles);
    bus.s_axis_tvalid = valid;
    bus.m_axis_tready = ready;
    repeat (cycles) step();
  endtask

  task automatic waitLog(int n, int budget);
    int k = 0;
    while (tid_log.size() < n && k < budget) begin
      step();
      k++;
    end
    if (tid_log.size() < n) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL handshake_timeout: got %0d handshakes, expected %0d", tid_log.size(), n);
    end
  endtask

  always @(posedge aclk) cyc++;

  // Reference model: arbitration computed from the rules directly.
  always @(posedge aclk or posedge areset) begin
    int w;
    if (areset) begin
      m_ptr = 0;
      m_holding = 1'b0;
      m_gap = 0;
      exp_q.delete();
    end else if (m_holding) begin
      if (bus.m_axis_tready) begin
        m_holding = 1'b0;
        m_gap = longint'(cfg_data);
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      w = pick(bus.s_axis_tvalid, m_ptr);
      if (w >= 0) begin
        exp_q.push_back('{id: w, data: bus.s_axis_tdata[w*DW +: DW]});
        m_holding = 1'b1;
        m_ptr = (w + 1) % NP;
      end
    end
  end

  always @(negedge aclk) begin
    logic [NP-1:0] exp_rdy;
    int w;
    w = pick(bus.s_axis_tvalid, m_ptr);
    exp_rdy = '0;
    if (!areset && !m_holding && m_gap == 0 && w >= 0) exp_rdy[w] = 1'b1;
    checkOutput("s_axis_tready", DW'(bus.s_axis_tready), DW'(exp_rdy));
    checkOutput("m_axis_tvalid", DW'(bus.m_axis_tvalid), DW'(m_holding));
    checkOutput("busy", DW'(busy), DW'(m_holding || m_gap != 0));
    if (bus.m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_word: got tid %0d, expected no output", bus.m_axis_tid);
      end else begin
        checkOutput("m_axis_tid", DW'(bus.m_axis_tid), DW'(exp_q[0].id));
        checkOutput("m_axis_tdata", bus.m_axis_tdata, exp_q[0].data);
        if (bus.m_axis_tready) begin
          tid_log.push_back(int'(bus.m_axis_tid));
          hs_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rc;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.m_axis_tready = 1'b0;
    #1 areset = 1'b1;

    // Reset with every source requesting.
    for (int i = 0; i < NP; i++) bus.s_axis_tdata[i*DW +: DW] = RR_BASE + DW'(i);
    bus.s_axis_tvalid = '1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    #1;
    checkOutput("reset_tready", DW'(bus.s_axis_tready), '0);
    checkOutput("reset_tvalid", DW'(bus.m_axis_tvalid), '0);
    checkOutput("reset_tid", DW'(bus.m_axis_tid), '0);
    step();
    tid_log.delete();
    hs_cyc.delete();
    cfg_data = '0;
    bus.m_axis_tready = 1'b1;
    areset = 1'b0;

    // Round robin: all ports valid, no gap, sink always ready.
    waitLog(6, 40);
    for (int k = 0; k < 6; k++) checkOutput("rr_order", DW'(tid_log[k]), DW'(k % NP));
    for (int k = 0; k < 5; k++) checkOutput("rr_spacing", DW'(hs_cyc[k+1] - hs_cyc[k]), DW'(2));
    applyStimulus('0, 1'b1, 8);

    // Gap of 5; the shorter cfg_data written mid-gap must not cut it short.
    cfg_data = 32'd5;
    tid_log.delete();
    hs_cyc.delete();
    bus.s_axis_tvalid = 4'b0100;
    waitLog(1, 40);
    repeat (2) step();
    cfg_data = 32'd1;
    waitLog(2, 40);
    checkOutput("gap_spacing", DW'(hs_cyc[1] - hs_cyc[0]), DW'(7));
    checkOutput("gap_tid", DW'(tid_log[1]), DW'(2));
    applyStimulus('0, 1'b1, 12);

    // Backpressure for 10 cycles while a word is held.
    cfg_data = '0;
    tid_log.delete();
    hs_cyc.delete();
    for (int i = 0; i < NP; i++) bus.s_axis_tdata[i*DW +: DW] = {$urandom, $urandom, $urandom};
    applyStimulus('1, 1'b0, 11);
    bus.m_axis_tready = 1'b1;
    rc = cyc;
    waitLog(1, 5);
    checkOutput("bp_first_ready", DW'(hs_cyc[0]), DW'(rc));
    applyStimulus('0, 1'b1, 4);
    checkOutput("bp_drained", DW'(exp_q.size()), '0);

    // Sparse requests exercising pointer skip and wrap.
    areset = 1'b1;
    step();
    areset = 1'b0;
    tid_log.delete();
    applyStimulus(4'b0001, 1'b1, 1);
    applyStimulus(4'b0000, 1'b1, 3);
    applyStimulus(4'b1000, 1'b1, 1);
    applyStimulus(4'b0000, 1'b1, 3);
    applyStimulus(4'b1001, 1'b1, 1);
    applyStimulus(4'b0000, 1'b1, 3);
    checkOutput("sparse_count", DW'(tid_log.size()), DW'(3));
    checkOutput("sparse_0", DW'(tid_log[0]), DW'(0));
    checkOutput("sparse_1", DW'(tid_log[1]), DW'(3));
    checkOutput("sparse_2", DW'(tid_log[2]), DW'(0));

    // Randomized traffic, backpressure and gaps.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NP; i++) bus.s_axis_tdata[i*DW +: DW] = {$urandom, $urandom, $urandom};
      cfg_data = CW'($urandom_range(0, 3));
      applyStimulus(NP'($urandom), $urandom_range(0, 3) != 0, 1);
    end
    cfg_data = '0;
    applyStimulus('0, 1'b1, 10);

    // Asynchronous reset between edges while a word is in SEND.
    applyStimulus(4'b0010, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 1);
    #2 areset = 1'b1;
    #1;
    checkOutput("async_send_tvalid", DW'(bus.m_axis_tvalid), '0);
    checkOutput("async_send_busy", DW'(busy), '0);
    step();
    areset = 1'b0;
    tid_log.delete();
    applyStimulus('1, 1'b1, 1);
    applyStimulus('0, 1'b1, 3);
    checkOutput("async_send_ptr", DW'(tid_log[0]), DW'(0));

    // Asynchronous reset between edges while in GAP.
    cfg_data = 32'd20;
    applyStimulus(4'b0010, 1'b1, 1);
    applyStimulus('1, 1'b1, 4);
    checkOutput("gap_busy_before", DW'(busy), DW'(1));
    #2 areset = 1'b1;
    #1;
    checkOutput("async_gap_busy", DW'(busy), '0);
    checkOutput("async_gap_tready", DW'(bus.s_axis_tready), '0);
    step();
    cfg_data = '0;
    areset = 1'b0;
    tid_log.delete();
    applyStimulus('1, 1'b1, 1);
    applyStimulus('0, 1'b1, 3);
    checkOutput("async_gap_ptr", DW'(tid_log[0]), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
